alu_wb: RTL
===========

# alu_wb

Writeback stage directly downstream of the combinational `alu`. It registers one ALU result per handshake and drives the single register-file write port. It sequences double-width results (MUL, DIV, SL, SR with `r_high_en`) into two consecutive writes. It also holds the architectural carry and compare flags: the carry register feeds the ALU `cin` input, and the flags feed branch logic.

## Interface
Parameters:
- `WORD`, 8, datapath width; matches `alu` WORD.
- `REGADDR`, 2, register-file address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  execute stage presents a valid ALU result.
- `in_ready`  out  1  stage can accept this cycle.
- `in_wr_en`  in  1  result is written to the register file; 0 means a flags-only operation.
- `in_rd`  in  REGADDR  destination register for the low word.
- `in_r`  in  WORD  ALU `r`.
- `in_r_high`  in  WORD  ALU `r_high`.
- `in_r_high_en`  in  1  ALU `r_high_en`.
- `in_cout`, `in_cout_en`  in  1 each  ALU carry-out and its enable.
- `in_zero`, `in_eq`, `in_gt`, `in_overflow`  in  1 each  ALU flags.
- `rf_we`  out  1  register-file write enable.
- `rf_addr`  out  REGADDR  write address.
- `rf_data`  out  WORD  write data.
- `carry`  out  1  architectural carry; wired to ALU `cin`.
- `flag_zero`, `flag_eq`, `flag_gt`, `flag_ovf`  out  1 each  architectural flags.
- `busy`  out  1  a write is in progress (state is not IDLE).

## Operation
- Accept condition: `acc = in_valid & in_ready`.
  - On `acc`, capture `rd_q`, `r_q`, `rh_q`, `we_q = in_wr_en`, `hi_q = in_wr_en & in_r_high_en`.
- FSM states: IDLE, LO, HI.
  - IDLE -> LO on `acc`; otherwise stay in IDLE.
  - LO: if `hi_q`, go to HI. Else if `acc`, stay in LO (new capture). Else go to IDLE.
  - HI: LO on `acc`, else IDLE.
- Ready: `in_ready = !(state==LO && hi_q)`.
  - Ready is low only during the low beat of a double-width result.
  - Ready is high in IDLE and HI.
- Outputs per state:
  - LO: `rf_we = we_q`, `rf_addr = rd_q`, `rf_data = r_q`.
  - HI: `rf_we = 1`, `rf_addr = rd_q + 1` (mod 2^REGADDR; register 3 wraps to 0), `rf_data = rh_q`.
  - IDLE: `rf_we = 0`; `rf_addr` and `rf_data` hold their last values.
- Flags are registered on `acc` only:
  - `flag_zero`, `flag_eq`, `flag_gt` and `flag_ovf` load on every accepted operation, including flags-only ones.
  - `carry` loads `in_cout` only when `in_cout_en = 1`; otherwise it holds.
- A flags-only double-width op (`in_wr_en = 0`, `in_r_high_en = 1`):
  - has `hi_q = 0`, so it takes a single LO beat with `rf_we = 0`;
  - `rh_q` is ignored.
- When `in_valid` is low, all inputs other than `in_valid` are don't-care. Nothing is captured.

## Timing
- Reset (at any cycle, including mid-sequence):
  - state = IDLE; `rf_we`, `rf_addr`, `rf_data`, `carry`, all flags and `busy` = 0; `in_ready` = 1.
  - Any pending HI write is dropped.
- Low-word latency: accept at edge N; `rf_we` is asserted in cycle N..N+1 and commits at edge N+1.
- High-word latency: the HI write occupies the following cycle and commits at edge N+2.
- Throughput:
  - single-width ops: one per cycle, back-to-back with no bubble;
  - double-width ops: one per two cycles.
- Flag and carry visibility: values captured at edge N are visible on `carry` and the flags from cycle N onward.
  - The ALU therefore uses the updated `cin` for an op issued immediately after.
- A new accept in HI leads to LO at the next edge. The HI write completes in the same cycle and is never lost.
- `in_ready` is a function of registered state only, with no combinational path from `in_valid`.

## Test plan
- Reset, then idle: `rf_we = 0`, `carry = 0`, `in_ready = 1`, `busy = 0`.
- ADD back-to-back with `in_rd` = 1 and `in_r` = 220, then `in_rd` = 2 and `in_r` = 20 on consecutive cycles:
  - `rf_we` is high for 2 consecutive cycles, with (1, 220) then (2, 20);
  - `in_ready` stays 1 throughout.
- MUL with `in_rd` = 3, `in_r` = 0x90, `in_r_high` = 0x01, `in_r_high_en` = 1:
  - write (3, 0x90) then (0, 0x01), showing wrap-around;
  - `in_ready` = 0 only during the first write.
- ADD with `in_cout` = 1 and `in_cout_en` = 1:
  - `carry` = 1 from the next cycle.
- Following AND with `in_cout` = 0 and `in_cout_en` = 0:
  - `carry` stays 1;
  - `flag_zero` follows `in_zero`.
- Flags-only SUB (`in_wr_en` = 0, `in_zero` = 1, `in_eq` = 1):
  - `rf_we` stays 0;
  - `flag_zero` = 1 and `flag_eq` = 1.
- DIV accepted, with `rst` asserted during its LO beat:
  - next cycle is IDLE, no HI write occurs, and all outputs are 0.

Source files
------------

// File: rtl/alu_wb.sv
// alu_wb: ALU writeback stage sequencing single/double-width register writes and holding carry/compare flags
module alu_wb #(
  parameter int WORD    = 8,
  parameter int REGADDR = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_wr_en,
  input  logic [REGADDR-1:0] in_rd,
  input  logic [WORD-1:0]    in_r,
  input  logic [WORD-1:0]    in_r_high,
  input  logic               in_r_high_en,
  input  logic               in_cout,
  input  logic               in_cout_en,
  input  logic               in_zero,
  input  logic               in_eq,
  input  logic               in_gt,
  input  logic               in_overflow,
  output logic               rf_we,
  output logic [REGADDR-1:0] rf_addr,
  output logic [WORD-1:0]    rf_data,
  output logic               carry,
  output logic               flag_zero,
  output logic               flag_eq,
  output logic               flag_gt,
  output logic               flag_ovf,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  state_t             state_q, state_d;
  logic [REGADDR-1:0] rf_addr_q, rf_addr_d;
  logic [WORD-1:0]    rf_data_q, rf_data_d, rh_q, rh_d;
  logic               rf_we_q, rf_we_d, hi_q, hi_d, carry_q, carry_d;
  logic [3:0]         flags_q, flags_d;
  logic               acc, hi_beat;
  assign in_ready = !(state_q == LO && hi_q);
  assign acc      = in_valid & in_ready;
  assign hi_beat  = state_q == LO && hi_q;
  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_data  = rf_data_q;
  assign carry    = carry_q;
  assign {flag_zero, flag_eq, flag_gt, flag_ovf} = flags_q;
  assign busy     = state_q != IDLE;
  // next state, next write beat (registered outputs), captured high word and flags
  always_comb begin
    state_d   = hi_beat ? HI : acc ? LO : IDLE;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    rh_d      = rh_q;
    hi_d      = 1'b0;
    carry_d   = acc && in_cout_en ? in_cout : carry_q;
    flags_d   = acc ? {in_zero, in_eq, in_gt, in_overflow} : flags_q;
    if (acc) begin
      rf_we_d   = in_wr_en;
      rf_addr_d = in_rd;
      rf_data_d = in_r;
      rh_d      = in_r_high;
      hi_d      = in_wr_en & in_r_high_en;
    end else if (hi_beat) begin
      rf_we_d   = 1'b1;
      rf_addr_d = rf_addr_q + 1'b1;
      rf_data_d = rh_q;
    end
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      rh_q      <= '0;
      hi_q      <= 1'b0;
      carry_q   <= 1'b0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      rh_q      <= rh_d;
      hi_q      <= hi_d;
      carry_q   <= carry_d;
      flags_q   <= flags_d;
    end
  end
endmodule
